// File: rtl/axi4lite_rr_arbiter.sv
// 2:1 AXI4-Lite round-robin arbiter: shares one slave between masters M0 and M1,
// with one read or write in flight and channels forwarded combinationally for the owner.
module axi4lite_rr_arbiter #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32
) (
  input  logic                      A_CLK,
  input  logic                      A_RSTn,
  // master 0
  input  logic                      m0_aw_valid,
  output logic                      m0_aw_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] m0_aw_addr,
  input  logic                      m0_w_valid,
  output logic                      m0_w_ready,
  input  logic [AXI_DATA_WIDTH-1:0] m0_w_data,
  output logic                      m0_b_valid,
  input  logic                      m0_b_ready,
  output logic [1:0]                m0_b_resp,
  input  logic                      m0_ar_valid,
  output logic                      m0_ar_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] m0_ar_addr,
  output logic                      m0_r_valid,
  input  logic                      m0_r_ready,
  output logic [AXI_DATA_WIDTH-1:0] m0_r_data,
  output logic [1:0]                m0_r_resp,
  // master 1
  input  logic                      m1_aw_valid,
  output logic                      m1_aw_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] m1_aw_addr,
  input  logic                      m1_w_valid,
  output logic                      m1_w_ready,
  input  logic [AXI_DATA_WIDTH-1:0] m1_w_data,
  output logic                      m1_b_valid,
  input  logic                      m1_b_ready,
  output logic [1:0]                m1_b_resp,
  input  logic                      m1_ar_valid,
  output logic                      m1_ar_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] m1_ar_addr,
  output logic                      m1_r_valid,
  input  logic                      m1_r_ready,
  output logic [AXI_DATA_WIDTH-1:0] m1_r_data,
  output logic [1:0]                m1_r_resp,
  // shared slave
  output logic                      s_aw_valid,
  input  logic                      s_aw_ready,
  output logic [AXI_ADDR_WIDTH-1:0] s_aw_addr,
  output logic                      s_w_valid,
  input  logic                      s_w_ready,
  output logic [AXI_DATA_WIDTH-1:0] s_w_data,
  input  logic                      s_b_valid,
  output logic                      s_b_ready,
  input  logic [1:0]                s_b_resp,
  output logic                      s_ar_valid,
  input  logic                      s_ar_ready,
  output logic [AXI_ADDR_WIDTH-1:0] s_ar_addr,
  input  logic                      s_r_valid,
  output logic                      s_r_ready,
  input  logic [AXI_DATA_WIDTH-1:0] s_r_data,
  input  logic [1:0]                s_r_resp,
  // status
  output logic [1:0]                grant,
  output logic                      busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_owner_q, last_owner_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;

  logic                      req0, req1;
  logic                      own_aw_valid, own_w_valid, own_ar_valid, own_b_ready, own_r_ready;
  logic [AXI_ADDR_WIDTH-1:0] own_aw_addr, own_ar_addr;
  logic [AXI_DATA_WIDTH-1:0] own_w_data;

  logic                      in_wr, in_wr_resp, in_rd_addr, in_rd_data;
  logic                      aw_hs, w_hs, b_hs, ar_hs, r_hs;

  logic                      mst_aw_ready, mst_w_ready, mst_b_valid, mst_ar_ready, mst_r_valid;
  logic [1:0]                mst_b_resp, mst_r_resp;
  logic [AXI_DATA_WIDTH-1:0] mst_r_data;

  assign req0 = m0_ar_valid | m0_aw_valid | m0_w_valid;
  assign req1 = m1_ar_valid | m1_aw_valid | m1_w_valid;

  // Request-side signals of whichever master currently owns the slave
  assign own_aw_valid = owner_q ? m1_aw_valid : m0_aw_valid;
  assign own_w_valid  = owner_q ? m1_w_valid  : m0_w_valid;
  assign own_ar_valid = owner_q ? m1_ar_valid : m0_ar_valid;
  assign own_b_ready  = owner_q ? m1_b_ready  : m0_b_ready;
  assign own_r_ready  = owner_q ? m1_r_ready  : m0_r_ready;
  assign own_aw_addr  = owner_q ? m1_aw_addr  : m0_aw_addr;
  assign own_ar_addr  = owner_q ? m1_ar_addr  : m0_ar_addr;
  assign own_w_data   = owner_q ? m1_w_data   : m0_w_data;

  assign in_wr      = (state_q == ST_WR);
  assign in_wr_resp = (state_q == ST_WR_RESP);
  assign in_rd_addr = (state_q == ST_RD_ADDR);
  assign in_rd_data = (state_q == ST_RD_DATA);

  assign aw_hs = s_aw_valid & s_aw_ready;
  assign w_hs  = s_w_valid  & s_w_ready;
  assign b_hs  = s_b_valid  & s_b_ready;
  assign ar_hs = s_ar_valid & s_ar_ready;
  assign r_hs  = s_r_valid  & s_r_ready;

  assign busy  = (state_q != ST_IDLE);
  assign grant = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge A_CLK) begin
    if (!A_RSTn) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

  // Arbitration and transaction sequencing
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          owner_d = (req0 && req1) ? ~last_owner_q : req1;
          state_d = (owner_d ? m1_ar_valid : m0_ar_valid) ? ST_RD_ADDR : ST_WR;
        end
      end
      ST_WR: begin
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d   = ST_WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end
      ST_WR_RESP: begin
        if (b_hs) begin
          state_d      = ST_IDLE;
          last_owner_d = owner_q;
        end
      end
      ST_RD_ADDR: begin
        if (ar_hs) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (r_hs) begin
          state_d      = ST_IDLE;
          last_owner_d = owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Slave-side forwarding; AW/W are masked once their handshake has been taken
  always_comb begin
    s_aw_addr  = '0;
    s_w_data   = '0;
    s_ar_addr  = '0;
    if (busy) begin
      s_aw_addr = own_aw_addr;
      s_w_data  = own_w_data;
      s_ar_addr = own_ar_addr;
    end
    s_aw_valid = in_wr & own_aw_valid & ~aw_done_q;
    s_w_valid  = in_wr & own_w_valid & ~w_done_q;
    s_b_ready  = in_wr_resp & own_b_ready;
    s_ar_valid = in_rd_addr & own_ar_valid;
    s_r_ready  = in_rd_data & own_r_ready;
  end

  assign mst_aw_ready = in_wr & s_aw_ready & ~aw_done_q;
  assign mst_w_ready  = in_wr & s_w_ready & ~w_done_q;
  assign mst_b_valid  = in_wr_resp & s_b_valid;
  assign mst_b_resp   = in_wr_resp ? s_b_resp : 2'b00;
  assign mst_ar_ready = in_rd_addr & s_ar_ready;
  assign mst_r_valid  = in_rd_data & s_r_valid;
  assign mst_r_data   = in_rd_data ? s_r_data : '0;
  assign mst_r_resp   = in_rd_data ? s_r_resp : 2'b00;

  // Route responses to the owner only; the other master sees all zeros
  always_comb begin
    m0_aw_ready = 1'b0;
    m0_w_ready  = 1'b0;
    m0_b_valid  = 1'b0;
    m0_b_resp   = 2'b00;
    m0_ar_ready = 1'b0;
    m0_r_valid  = 1'b0;
    m0_r_data   = '0;
    m0_r_resp   = 2'b00;
    m1_aw_ready = 1'b0;
    m1_w_ready  = 1'b0;
    m1_b_valid  = 1'b0;
    m1_b_resp   = 2'b00;
    m1_ar_ready = 1'b0;
    m1_r_valid  = 1'b0;
    m1_r_data   = '0;
    m1_r_resp   = 2'b00;
    if (busy && !owner_q) begin
      m0_aw_ready = mst_aw_ready;
      m0_w_ready  = mst_w_ready;
      m0_b_valid  = mst_b_valid;
      m0_b_resp   = mst_b_resp;
      m0_ar_ready = mst_ar_ready;
      m0_r_valid  = mst_r_valid;
      m0_r_data   = mst_r_data;
      m0_r_resp   = mst_r_resp;
    end else if (busy && owner_q) begin
      m1_aw_ready = mst_aw_ready;
      m1_w_ready  = mst_w_ready;
      m1_b_valid  = mst_b_valid;
      m1_b_resp   = mst_b_resp;
      m1_ar_ready = mst_ar_ready;
      m1_r_valid  = mst_r_valid;
      m1_r_data   = mst_r_data;
      m1_r_resp   = mst_r_resp;
    end
  end

endmodule

// File: tb/tb_axi4lite_rr_arbiter.sv
// Bench for axi4lite_rr_arbiter: directed master traffic, a simple register slave model,
// and a scoreboard monitor that checks every slave-side and response handshake in order.
module tb_axi4lite_rr_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int K_AW = 0, K_W = 1, K_B = 2, K_AR = 3, K_R = 4;

  typedef struct {
    int          kind;
    logic [1:0]  g;
    logic [31:0] v;
    logic [1:0]  r;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic clk;
  logic rst_n;

  logic          m_aw_valid[2], m_aw_ready[2], m_w_valid[2], m_w_ready[2];
  logic          m_b_valid[2], m_b_ready[2], m_ar_valid[2], m_ar_ready[2];
  logic          m_r_valid[2], m_r_ready[2];
  logic [AW-1:0] m_aw_addr[2], m_ar_addr[2];
  logic [DW-1:0] m_w_data[2], m_r_data[2];
  logic [1:0]    m_b_resp[2], m_r_resp[2];

  logic          s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_b_valid, s_b_ready;
  logic          s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
  logic [AW-1:0] s_aw_addr, s_ar_addr;
  logic [DW-1:0] s_w_data, s_r_data;
  logic [1:0]    s_b_resp, s_r_resp;
  logic [1:0]    grant;
  logic          busy;

  axi4lite_rr_arbiter #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .A_CLK(clk), .A_RSTn(rst_n),
    .m0_aw_valid(m_aw_valid[0]), .m0_aw_ready(m_aw_ready[0]), .m0_aw_addr(m_aw_addr[0]),
    .m0_w_valid(m_w_valid[0]), .m0_w_ready(m_w_ready[0]), .m0_w_data(m_w_data[0]),
    .m0_b_valid(m_b_valid[0]), .m0_b_ready(m_b_ready[0]), .m0_b_resp(m_b_resp[0]),
    .m0_ar_valid(m_ar_valid[0]), .m0_ar_ready(m_ar_ready[0]), .m0_ar_addr(m_ar_addr[0]),
    .m0_r_valid(m_r_valid[0]), .m0_r_ready(m_r_ready[0]), .m0_r_data(m_r_data[0]),
    .m0_r_resp(m_r_resp[0]),
    .m1_aw_valid(m_aw_valid[1]), .m1_aw_ready(m_aw_ready[1]), .m1_aw_addr(m_aw_addr[1]),
    .m1_w_valid(m_w_valid[1]), .m1_w_ready(m_w_ready[1]), .m1_w_data(m_w_data[1]),
    .m1_b_valid(m_b_valid[1]), .m1_b_ready(m_b_ready[1]), .m1_b_resp(m_b_resp[1]),
    .m1_ar_valid(m_ar_valid[1]), .m1_ar_ready(m_ar_ready[1]), .m1_ar_addr(m_ar_addr[1]),
    .m1_r_valid(m_r_valid[1]), .m1_r_ready(m_r_ready[1]), .m1_r_data(m_r_data[1]),
    .m1_r_resp(m_r_resp[1]),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_resp(s_b_resp),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_resp(s_r_resp),
    .grant(grant), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_push(input int kind, input logic [1:0] g, input logic [31:0] v,
                         input logic [1:0] r);
    exp_t e;
    e.kind = kind; e.g = g; e.v = v; e.r = r;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input int kind, input logic [1:0] g, input logic [31:0] v,
                          input logic [1:0] r);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got kind=%0d grant=%b val=%h resp=%b, none expected",
               kind, g, v, r);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != kind || e.g !== g || e.v !== v || e.r !== r) begin
        n_fail++;
        $display("FAIL sb_event: got kind=%0d grant=%b val=%h resp=%b expected kind=%0d grant=%b val=%h resp=%b",
                 kind, g, v, r, e.kind, e.g, e.v, e.r);
      end
    end
  endtask

  // Register-slave model: always ready on AW/W/AR; B resp = addr[3:2], R data = {addr[15:0], C0DE}
  logic          sl_rst, sl_aw_h, sl_w_h, sl_b_h, sl_ar_h, sl_r_h, sl_got_aw, sl_got_w;
  logic [AW-1:0] sl_aw_a, sl_ar_a, sl_wa;
  initial begin
    s_aw_ready = 1'b1; s_w_ready = 1'b1; s_ar_ready = 1'b1;
    s_b_valid = 1'b0; s_b_resp = 2'b00; s_r_valid = 1'b0; s_r_data = '0; s_r_resp = 2'b00;
    sl_got_aw = 1'b0; sl_got_w = 1'b0; sl_wa = '0;
    forever begin
      @(negedge clk);
      sl_rst  = rst_n;
      sl_aw_h = s_aw_valid & s_aw_ready;
      sl_w_h  = s_w_valid & s_w_ready;
      sl_b_h  = s_b_valid & s_b_ready;
      sl_ar_h = s_ar_valid & s_ar_ready;
      sl_r_h  = s_r_valid & s_r_ready;
      sl_aw_a = s_aw_addr;
      sl_ar_a = s_ar_addr;
      @(posedge clk); #1;
      if (!sl_rst) begin
        s_b_valid = 1'b0; s_b_resp = 2'b00; s_r_valid = 1'b0; s_r_data = '0; s_r_resp = 2'b00;
        sl_got_aw = 1'b0; sl_got_w = 1'b0;
      end else begin
        if (sl_b_h) begin s_b_valid = 1'b0; sl_got_aw = 1'b0; sl_got_w = 1'b0; end
        if (sl_aw_h) begin sl_got_aw = 1'b1; sl_wa = sl_aw_a; end
        if (sl_w_h) sl_got_w = 1'b1;
        if (sl_got_aw && sl_got_w && !s_b_valid) begin
          s_b_valid = 1'b1;
          s_b_resp  = sl_wa[3:2];
        end
        if (sl_r_h) s_r_valid = 1'b0;
        if (sl_ar_h) begin
          s_r_valid = 1'b1;
          s_r_data  = {sl_ar_a[15:0], 16'hC0DE};
          s_r_resp  = sl_ar_a[3:2];
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks the non-owner stays silent
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (s_ar_valid && s_ar_ready) sb_check(K_AR, grant, s_ar_addr, 2'b00);
      if (s_aw_valid && s_aw_ready) sb_check(K_AW, grant, s_aw_addr, 2'b00);
      if (s_w_valid && s_w_ready)   sb_check(K_W, grant, s_w_data, 2'b00);
      for (int n = 0; n < 2; n++)
        if (m_b_valid[n] && m_b_ready[n]) sb_check(K_B, 2'(1 << n), 32'd0, m_b_resp[n]);
      for (int n = 0; n < 2; n++)
        if (m_r_valid[n] && m_r_ready[n]) sb_check(K_R, 2'(1 << n), m_r_data[n], m_r_resp[n]);
      for (int n = 0; n < 2; n++)
        if (!grant[n])
          chk($sformatf("m%0d_quiet", n),
              32'(m_aw_ready[n] | m_w_ready[n] | m_b_valid[n] | m_ar_ready[n] | m_r_valid[n]
                  | (|m_r_data[n]) | (|m_b_resp[n]) | (|m_r_resp[n])), 32'd0);
      if (grant == 2'b00)
        chk("slave_quiet", 32'(s_aw_valid | s_w_valid | s_ar_valid | s_b_ready | s_r_ready
                              | (|s_aw_addr) | (|s_w_data) | (|s_ar_addr)), 32'd0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int n, input logic [31:0] addr);
    logic got;
    int   k;
    m_ar_addr[n] = addr; m_ar_valid[n] = 1'b1;
    got = 1'b0; k = 0;
    while (!got && k < 200) begin
      @(negedge clk); got = m_ar_ready[n];
      @(posedge clk); #1; k++;
    end
    m_ar_valid[n] = 1'b0;
    chk($sformatf("rd_ar_timeout_m%0d", n), 32'(got), 32'd1);
    m_r_ready[n] = 1'b1;
    got = 1'b0; k = 0;
    while (!got && k < 200) begin
      @(negedge clk); got = m_r_valid[n];
      @(posedge clk); #1; k++;
    end
    m_r_ready[n] = 1'b0;
    chk($sformatf("rd_r_timeout_m%0d", n), 32'(got), 32'd1);
  endtask

  task automatic do_write(input int n, input logic [31:0] addr, input logic [31:0] data,
                          input int w_lead, input bit no_b);
    logic aw_pend, w_pend, aw_h, w_h, got;
    int   k;
    m_aw_addr[n] = addr; m_w_data[n] = data; m_w_valid[n] = 1'b1;
    if (w_lead == 0) m_aw_valid[n] = 1'b1;
    aw_pend = 1'b1; w_pend = 1'b1; k = 0;
    while ((aw_pend || w_pend) && k < 200) begin
      @(negedge clk);
      aw_h = m_aw_valid[n] & m_aw_ready[n];
      w_h  = m_w_valid[n] & m_w_ready[n];
      @(posedge clk); #1; k++;
      if (aw_h) begin m_aw_valid[n] = 1'b0; aw_pend = 1'b0; end
      if (w_h)  begin m_w_valid[n] = 1'b0;  w_pend = 1'b0;  end
      if (aw_pend && !m_aw_valid[n] && k == w_lead) m_aw_valid[n] = 1'b1;
    end
    m_aw_valid[n] = 1'b0; m_w_valid[n] = 1'b0;
    chk($sformatf("wr_aw_w_timeout_m%0d", n), 32'(aw_pend | w_pend), 32'd0);
    if (!no_b) begin
      m_b_ready[n] = 1'b1;
      got = 1'b0; k = 0;
      while (!got && k < 200) begin
        @(negedge clk); got = m_b_valid[n];
        @(posedge clk); #1; k++;
      end
      m_b_ready[n] = 1'b0;
      chk($sformatf("wr_b_timeout_m%0d", n), 32'(got), 32'd1);
    end
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0;
    for (int n = 0; n < 2; n++) begin
      m_aw_valid[n] = 1'b0; m_w_valid[n] = 1'b0; m_b_ready[n] = 1'b0;
      m_ar_valid[n] = 1'b0; m_r_ready[n] = 1'b0;
      m_aw_addr[n] = '0; m_ar_addr[n] = '0; m_w_data[n] = '0;
    end

    // Reset with both masters requesting reads
    m_ar_addr[0] = 32'h100; m_ar_addr[1] = 32'h104;
    m_ar_valid[0] = 1'b1;   m_ar_valid[1] = 1'b1;
    m_w_valid[0]  = 1'b1;   m_aw_valid[1] = 1'b1;
    @(posedge clk); #1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_handshakes", 32'({m_ar_ready[0], m_ar_ready[1], m_aw_ready[0], m_aw_ready[1],
                                  m_w_ready[0], m_w_ready[1], s_ar_valid, s_aw_valid,
                                  s_w_valid, m_b_valid[0], m_r_valid[1]}), 32'd0);
    end
    @(posedge clk); #1;
    m_w_valid[0] = 1'b0; m_aw_valid[1] = 1'b0;
    rst_n = 1'b1;
    sb_push(K_AR, 2'b01, 32'h0000_0100, 2'b00);
    sb_push(K_R,  2'b01, 32'h0100_C0DE, 2'b00);
    sb_push(K_AR, 2'b10, 32'h0000_0104, 2'b00);
    sb_push(K_R,  2'b10, 32'h0104_C0DE, 2'b01);
    fork
      do_read(0, 32'h100);
      do_read(1, 32'h104);
      begin
        @(negedge clk); chk("first_grant_latency", 32'(grant), 32'd0);
        @(negedge clk); chk("first_grant", 32'(grant), 32'd1);
      end
    join
    idle(2);

    // Single write from M1
    sb_push(K_AW, 2'b10, 32'h0000_0004, 2'b00);
    sb_push(K_W,  2'b10, 32'hDEAD_BEEF, 2'b00);
    sb_push(K_B,  2'b10, 32'd0,         2'b01);
    do_write(1, 32'h4, 32'hDEAD_BEEF, 0, 1'b0);
    idle(2);

    // Contention: alternating reads
    sb_push(K_AR, 2'b01, 32'h0000_0010, 2'b00);
    sb_push(K_R,  2'b01, 32'h0010_C0DE, 2'b00);
    sb_push(K_AR, 2'b10, 32'h0000_0014, 2'b00);
    sb_push(K_R,  2'b10, 32'h0014_C0DE, 2'b01);
    sb_push(K_AR, 2'b01, 32'h0000_0018, 2'b00);
    sb_push(K_R,  2'b01, 32'h0018_C0DE, 2'b10);
    sb_push(K_AR, 2'b10, 32'h0000_001C, 2'b00);
    sb_push(K_R,  2'b10, 32'h001C_C0DE, 2'b11);
    fork
      begin do_read(0, 32'h10); do_read(0, 32'h18); end
      begin do_read(1, 32'h14); do_read(1, 32'h1C); end
    join
    idle(2);

    // Skewed write: W leads AW by 3 cycles
    sb_push(K_W,  2'b01, 32'h1234_5678, 2'b00);
    sb_push(K_AW, 2'b01, 32'h0000_000C, 2'b00);
    sb_push(K_B,  2'b01, 32'd0,         2'b11);
    do_write(0, 32'hC, 32'h1234_5678, 3, 1'b0);
    idle(2);

    // Mixed read+write from M0: read first, one idle cycle, then write
    sb_push(K_AR, 2'b01, 32'h0000_0030, 2'b00);
    sb_push(K_R,  2'b01, 32'h0030_C0DE, 2'b00);
    sb_push(K_AW, 2'b01, 32'h0000_0020, 2'b00);
    sb_push(K_W,  2'b01, 32'hCAFE_F00D, 2'b00);
    sb_push(K_B,  2'b01, 32'd0,         2'b00);
    fork
      do_read(0, 32'h30);
      do_write(0, 32'h20, 32'hCAFE_F00D, 0, 1'b0);
      begin
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
          @(negedge clk);
          seen = m_r_valid[0] & m_r_ready[0];
        end
        chk("mixed_r_seen", 32'(seen), 32'd1);
        @(negedge clk); chk("mixed_idle_gap", 32'(busy), 32'd0);
        @(negedge clk); chk("mixed_write_grant", 32'({busy, grant}), 32'b101);
      end
    join
    idle(2);

    // Reset during WR_RESP abandons the write
    sb_push(K_AW, 2'b10, 32'h0000_0008, 2'b00);
    sb_push(K_W,  2'b10, 32'h55AA_55AA, 2'b00);
    do_write(1, 32'h8, 32'h55AA_55AA, 0, 1'b1);
    @(negedge clk);
    chk("wr_resp_pending", 32'({busy, grant, m_b_valid[1]}), 32'b1101);
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_bvalid", 32'({m_b_valid[0], m_b_valid[1]}), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(2);

    // Recovery read from M1
    sb_push(K_AR, 2'b10, 32'h0000_0040, 2'b00);
    sb_push(K_R,  2'b10, 32'h0040_C0DE, 2'b00);
    do_read(1, 32'h40);
    idle(3);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
